alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Consumer end of the ALUControl interface that the ALU decoder drives.
- Takes a 3-bit ALUControl code with two operands over a valid/ready handshake, computes the result, and returns result plus flags through a 2-entry output buffer with its own valid/ready handshake.
- Sits between the control/decode stage and writeback/branch logic.
- Serves as the registered execute stage for the multi-cycle and pipelined core variants.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_control  input  3  operation code.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  buffer head holds a completed result.
- out_ready  input  1  downstream accepts the head this cycle.
- result  output  WIDTH  head result.
- zero  output  1  head result == 0.
- illegal  output  1  head was produced from an unsupported code.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low, on rst_n.
- Codes:
  - 000 add: A+B, mod 2^WIDTH.
  - 001 sub: A-B, mod 2^WIDTH.
  - 010 and: A&B.
  - 011 or: A|B.
  - 101 slt: result = 1 if A<B signed, else 0; upper bits are 0.
  - 100, 110, 111: result = 0, illegal = 1.
- slt computation:
  - Take the sign of the WIDTH-bit difference A-B, XOR signed overflow of that subtraction.
  - A plain unsigned compare is forbidden.
- Accept:
  - An operation is accepted on a rising edge with in_valid && in_ready.
  - alu_control, src_a and src_b are sampled only at the accept edge.
  - On acceptance, result, zero and illegal are computed combinationally and written into the buffer tail at that edge.
- Buffer:
  - 2-entry in-order FIFO with a registered count of 0..2.
  - in_ready = (count != 2); it is decoded from registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - result, zero and illegal always reflect the head entry.
  - While out_valid && !out_ready, the head and all outputs hold stable.
- Pop:
  - Occurs on an edge with out_valid && out_ready.
  - The next entry becomes head, or out_valid drops if the buffer empties.
- Latency: exactly 1 cycle. An op accepted at edge N is visible on the outputs after edge N when the buffer was empty.
- Throughput: one op per cycle while out_ready is held high.
- Boundary conditions:
  - Push and pop on the same edge at count 1: count stays 1, the new entry becomes head, order is preserved.
  - Push and pop on the same edge at count 0: only the push happens, since out_valid is low.
  - Count 2: in_ready is 0, so no push. A pop at that edge lowers count to 1, and in_ready rises after that edge.
  - in_valid while in_ready=0: the request is ignored. The requester must hold it; the unit keeps no memory of it.
- Reset values:
  - count = 0, in_ready = 1, out_valid = 0.
  - result = 0, zero = 0, illegal = 0 (all storage cleared).
- Reset mid-operation:
  - All buffered results are discarded immediately.
  - No output pulse occurs after reset release.
  - The first accept is possible on the first clk edge with rst_n high.
- Unknown handling: X on alu_control while in_valid=0 has no effect on state.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), stored per buffer entry.
  - overflow = signed two's-complement overflow for add and sub.
  - overflow = 0 for and, or and slt, and 0 for illegal codes.
  - overflow reset value is 0.
- Undefined:
  - The port does not exist.
  - No overflow storage is instantiated.
  - All other behaviour is identical.

Test Plan:
- Basic ops (WIDTH=32, out_ready=1):
  - add 5+7 -> result=12, zero=0.
  - sub 7-7 -> result=0, zero=1.
  - and F0F0_F0F0&0FF0_0FF0 -> 00F0_00F0.
  - or 1|2 -> 3.
  - Each output appears one cycle after accept.
- Signed slt:
  - FFFF_FFFF vs 0000_0001 -> 1.
  - 8000_0000 vs 7FFF_FFFF -> 1 (overflow case).
  - 7FFF_FFFF vs 8000_0000 -> 0.
- Illegal codes 100/110/111 with A=3, B=4 -> result=0, illegal=1.
  - A following add on the next op -> illegal=0.
- Backpressure:
  - Hold out_ready=0 and issue 3 back-to-back adds (1+1, 2+2, 3+3).
  - Required: the first two are accepted, in_ready=0 on the third cycle, result holds 2.
  - Release out_ready: results 2, 4, 6 come out in order; the third op is accepted the cycle after the first pop.
- Reset mid-flight:
  - With count=2, assert rst_n=0 asynchronously between edges.
  - Required: out_valid and result drop to 0 immediately, in_ready=1.
  - After release, a single add 9+1 yields 10 with no stale outputs.
- With ALU_OVERFLOW_EN:
  - add 7FFF_FFFF+1 -> result=8000_0000, overflow=1.
  - sub 8000_0000-1 -> overflow=1.
  - or of the same operands -> overflow=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage.
// Accepts {alu_control, src_a, src_b} over valid/ready, computes result/zero/illegal,
// and returns them through a 2-entry in-order output buffer with its own valid/ready.
// Optional macro ALU_OVERFLOW_EN adds a per-entry signed overflow flag and port.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             illegal
);

`ifdef ALU_OVERFLOW_EN
    localparam int unsigned EntryW = WIDTH + 3;
`else
    localparam int unsigned EntryW = WIDTH + 2;
`endif
    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b101;

    logic [WIDTH-1:0]  sum, diff, res;
    logic              sub_ovf, ill;
    logic [EntryW-1:0] entry_new, head;
    logic [EntryW-1:0] mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              push, pop;

    // Datapath: decode the op code and compute the result for the incoming request.
    always_comb begin
        sum     = src_a + src_b;
        diff    = src_a - src_b;
        sub_ovf = (src_a[Msb] != src_b[Msb]) && (diff[Msb] != src_a[Msb]);
        res     = '0;
        ill     = 1'b0;
        case (alu_control)
            OpAdd:   res = sum;
            OpSub:   res = diff;
            OpAnd:   res = src_a & src_b;
            OpOr:    res = src_a | src_b;
            // Signed less-than: sign of the difference corrected by subtraction overflow.
            OpSlt:   res = WIDTH'(diff[Msb] ^ sub_ovf);
            default: ill = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic add_ovf, ovf;

    // Signed overflow is only meaningful for add and sub; every other code reports 0.
    always_comb begin
        add_ovf = (src_a[Msb] == src_b[Msb]) && (sum[Msb] != src_a[Msb]);
        ovf     = 1'b0;
        if (alu_control == OpAdd) begin
            ovf = add_ovf;
        end else if (alu_control == OpSub) begin
            ovf = sub_ovf;
        end
    end

    assign entry_new = {ovf, ill, (res == '0), res};
    assign overflow  = head[WIDTH+2];
`else
    assign entry_new = {ill, (res == '0), res};
`endif

    // Handshake decode uses registered count only, so in_ready never depends on out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head    = mem_q[rd_ptr_q];
    assign result  = head[WIDTH-1:0];
    assign zero    = head[WIDTH];
    assign illegal = head[WIDTH+1];

    // Occupancy next state; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Buffer storage, pointers and count; reset clears every entry so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= entry_new;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32): directed steps followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    alu_control = 3'b000;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          zero;
    logic          illegal;
`ifdef ALU_OVERFLOW_EN
    logic          overflow;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        ill;
        logic        ov;
    } exp_t;

    exp_t q[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
`ifdef ALU_OVERFLOW_EN
        .overflow    (overflow),
`endif
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        e  = '0;
        case (c)
            3'd0: begin
                s    = sa + sb;
                e.r  = s[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                s    = sa - sb;
                e.r  = s[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("result", result, q[0].r);
            chk("zero", {31'd0, zero}, {31'd0, q[0].z});
            chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
`ifdef ALU_OVERFLOW_EN
            chk("overflow", {31'd0, overflow}, {31'd0, q[0].ov});
`endif
        end
    endtask

    // One clock cycle: check state at the falling edge, drive inputs, update model at rising edge.
    task automatic step(input logic iv, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy);
        bit push, pop;
        exp_t e;
        @(negedge clk);
        check_outputs();
        in_valid    = iv;
        alu_control = c;
        src_a       = a;
        src_b       = b;
        out_ready   = ordy;
        push = iv && (q.size() < 2);
        pop  = (q.size() > 0) && ordy;
        e    = push ? model(c, a, b) : '0;
        @(posedge clk);
        if (pop) q.delete(0);
        if (push) q.push_back(e);
    endtask

    logic [31:0] corner [6];

    initial begin
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        corner[5] = 32'h0000_0007;

        // Reset values while held in reset
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ops, visible one cycle after accept
        step(1'b1, 3'b000, 32'd5, 32'd7, 1'b1);
        #1 chk("add_5_7", result, 32'd12);
        chk("add_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("add_zero", {31'd0, zero}, 32'd0);
        step(1'b1, 3'b001, 32'd7, 32'd7, 1'b1);
        #1 chk("sub_7_7", result, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        step(1'b1, 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
        #1 chk("and", result, 32'h00F0_00F0);
        step(1'b1, 3'b011, 32'd1, 32'd2, 1'b1);
        #1 chk("or", result, 32'd3);

        // Signed slt
        step(1'b1, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        #1 chk("slt_neg1_1", result, 32'd1);
        step(1'b1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        #1 chk("slt_min_max", result, 32'd1);
        step(1'b1, 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        #1 chk("slt_max_min", result, 32'd0);

        // Illegal codes then a legal add
        step(1'b1, 3'b100, 32'd3, 32'd4, 1'b1);
        #1 chk("ill100_res", result, 32'd0);
        chk("ill100_flag", {31'd0, illegal}, 32'd1);
        step(1'b1, 3'b110, 32'd3, 32'd4, 1'b1);
        #1 chk("ill110_flag", {31'd0, illegal}, 32'd1);
        step(1'b1, 3'b111, 32'd3, 32'd4, 1'b1);
        #1 chk("ill111_flag", {31'd0, illegal}, 32'd1);
        step(1'b1, 3'b000, 32'd3, 32'd4, 1'b1);
        #1 chk("post_ill_flag", {31'd0, illegal}, 32'd0);
        chk("post_ill_res", result, 32'd7);

`ifdef ALU_OVERFLOW_EN
        step(1'b1, 3'b000, 32'h7FFF_FFFF, 32'd1, 1'b1);
        #1 chk("ovf_add_res", result, 32'h8000_0000);
        chk("ovf_add", {31'd0, overflow}, 32'd1);
        step(1'b1, 3'b001, 32'h8000_0000, 32'd1, 1'b1);
        #1 chk("ovf_sub", {31'd0, overflow}, 32'd1);
        step(1'b1, 3'b011, 32'h8000_0000, 32'd1, 1'b1);
        #1 chk("ovf_or", {31'd0, overflow}, 32'd0);
`endif

        // Drain, then an idle cycle with an unknown op code
        step(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        step(1'b0, 3'bxxx, 32'd0, 32'd0, 1'b1);
        #1 chk("idle_x_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepted, third held off
        step(1'b1, 3'b000, 32'd1, 32'd1, 1'b0);
        step(1'b1, 3'b000, 32'd2, 32'd2, 1'b0);
        #1 chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", result, 32'd2);
        step(1'b1, 3'b000, 32'd3, 32'd3, 1'b0);
        #1 chk("bp_hold_head", result, 32'd2);
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 3'b000, 32'd3, 32'd3, 1'b1);
        #1 chk("bp_pop1", result, 32'd4);
        chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        step(1'b1, 3'b000, 32'd3, 32'd3, 1'b1);
        #1 chk("bp_pop2", result, 32'd6);
        step(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        #1 chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-flight with a full buffer
        step(1'b1, 3'b000, 32'd1, 32'd2, 1'b0);
        step(1'b1, 3'b000, 32'd3, 32'd4, 1'b0);
        #1 chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'b000, 32'd9, 32'd1, 1'b1);
        #1 chk("post_rst_add", result, 32'd10);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        #1 chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
                 $urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
